// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// bus_pkg : shared widths, timeout default and sequencer state encoding
// Rev 1.0
// ============================================================================
package bus_pkg;

    localparam int c_DATA_W      = 32;
    localparam int c_LEN_W       = 8;
    localparam int c_TIMEOUT_CYC = 1023;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_DATA   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// rr_arbiter_2 : two-way round-robin grant with registered last-grant pointer
// Rev 1.0
// ============================================================================
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic       o_grant_vld,
    output logic       o_grant_idx
);

    logic r_favour_1;
    logic w_pick_1;

    // A lone requester wins regardless of the pointer.
    assign w_pick_1    = i_req[1] & (~i_req[0] | r_favour_1);
    assign o_grant_vld = |i_req;
    assign o_grant_idx = w_pick_1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_favour_1 <= 1'b0;
        end else if (i_accept && o_grant_vld) begin
            r_favour_1 <= ~w_pick_1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_master_sequencer.sv
`default_nettype none
// ============================================================================
// bus_master_sequencer : two-client burst bus master (addr phase + data beats)
// Rev 1.0
// ============================================================================
module bus_master_sequencer
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYC = c_TIMEOUT_CYC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            cli_req,
    input  logic [1:0]            cli_we,
    input  logic [63:0]           cli_addr,
    input  logic [15:0]           cli_len,
    input  logic [63:0]           cli_wdata,
    output logic [1:0]            cli_wdata_pop,
    output logic [c_DATA_W-1:0]   cli_rdata,
    output logic [1:0]            cli_rdata_vld,
    output logic [1:0]            cli_done,
    output logic [1:0]            cli_err,
    output logic [c_DATA_W-1:0]   ad_o,
    output logic                  ad_o_enable,
    output logic                  stb,
    output logic                  we,
    output logic                  m_rdy,
    input  logic [c_DATA_W-1:0]   ad_in,
    input  logic                  ack,
    input  logic                  s_rdy,
    input  logic                  abort
);

    localparam int c_TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);

    state_t                r_state;
    logic                  r_gnt;
    logic                  r_we;
    logic [c_DATA_W-1:0]   r_addr;
    logic [c_LEN_W:0]      r_beats;
    logic [c_LEN_W:0]      r_remain;
    logic [c_TMO_W-1:0]    r_tmo;
    logic                  r_stb;
    logic                  r_we_o;
    logic                  r_m_rdy;
    logic                  r_ad_en;
    logic [c_DATA_W-1:0]   r_rdata;
    logic [1:0]            r_rdata_vld;
    logic [1:0]            r_done;
    logic [1:0]            r_err;

    logic                  w_gnt_vld;
    logic                  w_gnt_idx;
    logic                  w_start;
    logic                  w_busy;
    logic                  w_progress;
    logic                  w_beat;
    logic                  w_fin_ok;
    logic                  w_fin_err;
    logic [1:0]            w_gnt_mask;
    logic [c_LEN_W-1:0]    w_req_len;
    logic [c_DATA_W-1:0]   w_req_addr;
    logic [c_DATA_W-1:0]   w_wdata;

    rr_arbiter_2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_req       (cli_req),
        .i_accept    (r_state == ST_IDLE),
        .o_grant_vld (w_gnt_vld),
        .o_grant_idx (w_gnt_idx)
    );

    assign w_start    = (r_state == ST_IDLE) && w_gnt_vld;
    assign w_busy     = (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign w_progress = (r_state == ST_ADDR) ? ack :
                        (r_state == ST_DATA) ? s_rdy : 1'b0;
    // Abort overrides a coincident ack or beat.
    assign w_beat     = (r_state == ST_DATA) && s_rdy && !abort;
    assign w_fin_ok   = w_beat && (r_remain == {{c_LEN_W{1'b0}}, 1'b1});
    assign w_fin_err  = w_busy && (abort || (!w_progress && (r_tmo == c_TMO_LAST)));
    assign w_gnt_mask = r_gnt ? 2'b10 : 2'b01;
    assign w_req_len  = w_gnt_idx ? cli_len[15:8]    : cli_len[7:0];
    assign w_req_addr = w_gnt_idx ? cli_addr[63:32]  : cli_addr[31:0];
    assign w_wdata    = r_gnt     ? cli_wdata[63:32] : cli_wdata[31:0];

    // Write data and pops follow the live beat so the client can advance its
    // data for back-to-back s_rdy cycles.
    assign cli_wdata_pop = (w_beat && r_we) ? w_gnt_mask : 2'b00;
    assign ad_o          = (r_state == ST_ADDR)          ? r_addr  :
                           ((r_state == ST_DATA) && r_we) ? w_wdata : '0;
    assign ad_o_enable   = r_ad_en;
    assign stb           = r_stb;
    assign we            = r_we_o;
    assign m_rdy         = r_m_rdy;
    assign cli_rdata     = r_rdata;
    assign cli_rdata_vld = r_rdata_vld;
    assign cli_done      = r_done;
    assign cli_err       = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_beats     <= '0;
            r_remain    <= '0;
            r_tmo       <= '0;
            r_stb       <= 1'b0;
            r_we_o      <= 1'b0;
            r_m_rdy     <= 1'b0;
            r_ad_en     <= 1'b0;
            r_rdata     <= '0;
            r_rdata_vld <= 2'b00;
            r_done      <= 2'b00;
            r_err       <= 2'b00;
        end else begin
            r_done      <= 2'b00;
            r_err       <= 2'b00;
            r_rdata_vld <= 2'b00;

            if (w_beat && !r_we) begin
                r_rdata     <= ad_in;
                r_rdata_vld <= w_gnt_mask;
            end

            if (w_fin_err || w_fin_ok) begin
                r_state <= ST_FINISH;
                r_tmo   <= '0;
                r_stb   <= 1'b0;
                r_we_o  <= 1'b0;
                r_m_rdy <= 1'b0;
                r_ad_en <= 1'b0;
                r_done  <= w_gnt_mask;
                r_err   <= w_fin_err ? w_gnt_mask : 2'b00;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_state <= ST_ADDR;
                            r_gnt   <= w_gnt_idx;
                            r_we    <= cli_we[w_gnt_idx];
                            r_addr  <= w_req_addr;
                            r_beats <= {1'b0, w_req_len} + {{c_LEN_W{1'b0}}, 1'b1};
                            r_tmo   <= '0;
                            r_stb   <= 1'b1;
                            r_we_o  <= cli_we[w_gnt_idx];
                            r_ad_en <= 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        if (ack) begin
                            r_state  <= ST_DATA;
                            r_remain <= r_beats;
                            r_tmo    <= '0;
                            r_m_rdy  <= 1'b1;
                            r_ad_en  <= r_we;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (s_rdy) begin
                            r_remain <= r_remain - 1'b1;
                            r_tmo    <= '0;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                    ST_FINISH: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
